// File: rtl/sram_port_arbiter_if.sv
// Request/ack handshakes for ports A and B plus the byte-wide SRAM bus.
// slave = arbiter side; master = requesters together with the SRAM device.
interface sram_port_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [20:0] a_addr;
    logic [7:0]  a_wdata;
    logic        a_ack;
    logic [7:0]  a_rdata;

    logic        b_req;
    logic        b_we;
    logic [20:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_ack;
    logic [7:0]  b_rdata;

    logic        busy;
    logic [20:0] sram_addr;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din;
    logic        sram_we_n;
    logic        sram_oe_n;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  sram_din,
        output a_ack, a_rdata, b_ack, b_rdata,
        output busy, sram_addr, sram_dout, sram_we_n, sram_oe_n
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output sram_din,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  busy, sram_addr, sram_dout, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port byte-access sequencer for the external SRAM; SRAMARB_ROUNDROBIN_EN selects round-robin over fixed A priority.
// Read ack ACCESS_CYCLES after grant, write ack ACCESS_CYCLES+1; requests wait as held levels, no queue.
module sram_port_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input logic                sysclk,
    input logic                reset_n,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WSET,
        ST_WR,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_port_b;
    logic [20:0] r_addr;
    logic [7:0]  r_dout;
    logic        r_we_n;
    logic        r_oe_n;
    logic        r_a_ack;
    logic        r_b_ack;
    logic [7:0]  r_a_rdata;
    logic [7:0]  r_b_rdata;
    logic        r_busy;

    logic        w_any_req;
    logic        w_grant_b;
    logic        w_sel_we;
    logic [20:0] w_sel_addr;
    logic [7:0]  w_sel_wdata;

`ifdef SRAMARB_ROUNDROBIN_EN
    // Set when B should win the next tie, i.e. A was granted last.
    logic        r_rr_prio_b;

    assign w_grant_b = bus.b_req && (!bus.a_req || r_rr_prio_b);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_prio_b <= 1'b0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_rr_prio_b <= !w_grant_b;
        end
    end
`else
    assign w_grant_b = bus.b_req && !bus.a_req;
`endif

    assign w_any_req   = bus.a_req || bus.b_req;
    assign w_sel_we    = w_grant_b ? bus.b_we    : bus.a_we;
    assign w_sel_addr  = w_grant_b ? bus.b_addr  : bus.a_addr;
    assign w_sel_wdata = w_grant_b ? bus.b_wdata : bus.a_wdata;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_port_b  <= 1'b0;
            r_addr    <= 21'd0;
            r_dout    <= 8'd0;
            r_we_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= 8'd0;
            r_b_rdata <= 8'd0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    if (w_any_req) begin
                        r_port_b <= w_grant_b;
                        r_addr   <= w_sel_addr;
                        r_dout   <= w_sel_wdata;
                        r_cnt    <= CNT_LOAD;
                        r_busy   <= 1'b1;
                        if (w_sel_we) begin
                            r_state <= ST_WSET;
                        end else begin
                            r_state <= ST_RD;
                            r_oe_n  <= 1'b0;
                        end
                    end
                end
                ST_RD: begin
                    if (r_cnt == 4'd0) begin
                        if (r_port_b) begin
                            r_b_rdata <= bus.sram_din;
                            r_b_ack   <= 1'b1;
                        end else begin
                            r_a_rdata <= bus.sram_din;
                            r_a_ack   <= 1'b1;
                        end
                        r_oe_n  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                // Address and data have been stable for one cycle before the strobe falls.
                ST_WSET: begin
                    r_we_n  <= 1'b0;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    if (r_cnt == 4'd0) begin
                        r_we_n  <= 1'b1;
                        r_a_ack <= !r_port_b;
                        r_b_ack <= r_port_b;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                // Address hold cycle; requests are ignored so the acked requester can drop req.
                ST_DONE: begin
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_we_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_ack     = r_a_ack;
    assign bus.b_ack     = r_b_ack;
    assign bus.a_rdata   = r_a_rdata;
    assign bus.b_rdata   = r_b_rdata;
    assign bus.busy      = r_busy;
    assign bus.sram_addr = r_addr;
    assign bus.sram_dout = r_dout;
    assign bus.sram_we_n = r_we_n;
    assign bus.sram_oe_n = r_oe_n;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM device model, reference memory and timing expectations.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_sram_port_arbiter;
    localparam int AC = 2;
`ifdef SRAMARB_ROUNDROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic sysclk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail = 0;
    int   overlap_cnt = 0;

    sram_port_arbiter_if bif ();

    sram_port_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .sysclk (sysclk),
        .reset_n(reset_n),
        .bus    (bif)
    );

    logic [7:0] mem [0:2097151];
    logic [7:0] ref_mem [logic [20:0]];

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always_comb bif.sram_din = (bif.sram_oe_n === 1'b0) ? mem[bif.sram_addr] : 8'h00;
    always @(posedge sysclk) if (bif.sram_we_n === 1'b0) mem[bif.sram_addr] = bif.sram_dout;
    always @(negedge sysclk) if (reset_n && bif.sram_we_n === 1'b0 && bif.sram_oe_n === 1'b0) overlap_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic logic [20:0] pool_addr(input int i);
        logic [4:0] v;
        v = 5'(i);
        return {v[4], 16'h0000, v[3:0]};
    endfunction

    function automatic logic get_ack(input bit p);
        return p ? bif.b_ack : bif.a_ack;
    endfunction

    function automatic logic [7:0] get_rdata(input bit p);
        return p ? bif.b_rdata : bif.a_rdata;
    endfunction

    task automatic preload(input logic [20:0] a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic drive_req(input bit p, input bit req, input bit we, input logic [20:0] addr, input logic [7:0] wd);
        if (p) begin
            bif.b_req = req; bif.b_we = we; bif.b_addr = addr; bif.b_wdata = wd;
        end else begin
            bif.a_req = req; bif.a_we = we; bif.a_addr = addr; bif.a_wdata = wd;
        end
    endtask

    task automatic drop_req(input bit p);
        if (p) bif.b_req = 1'b0;
        else   bif.a_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge sysclk);
        reset_n = 1'b1;
        @(negedge sysclk);
    endtask

    // One isolated access with strobe and address observations for the caller to judge.
    task automatic access(input bit p, input bit we, input logic [20:0] addr, input logic [7:0] wd,
                          output int lat, output int oe_low, output int we_low,
                          output bit setup_ok, output bit other_ack);
        bit          prev_we_n;
        logic [20:0] prev_addr;
        @(negedge sysclk);
        drive_req(p, 1'b1, we, addr, wd);
        lat = -1; oe_low = 0; we_low = 0; setup_ok = 1'b1; other_ack = 1'b0;
        prev_we_n = bif.sram_we_n;
        prev_addr = bif.sram_addr;
        for (int k = 1; k <= 64; k++) begin
            @(negedge sysclk);
            if (bif.sram_oe_n === 1'b0) oe_low++;
            if (bif.sram_we_n === 1'b0) begin
                we_low++;
                if (bif.sram_addr !== addr) setup_ok = 1'b0;
                if (prev_we_n && prev_addr !== addr) setup_ok = 1'b0;
            end
            if (get_ack(!p) === 1'b1) other_ack = 1'b1;
            prev_we_n = bif.sram_we_n;
            prev_addr = bif.sram_addr;
            if (get_ack(p) === 1'b1) begin
                if (we && bif.sram_addr !== addr) setup_ok = 1'b0;
                lat = k - 1;
                drop_req(p);
                break;
            end
        end
        if (lat < 0) drop_req(p);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sysclk);
        n_tests++; if (bif.sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b expected 1", bif.sram_we_n); end
        n_tests++; if (bif.sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b expected 1", bif.sram_oe_n); end
        n_tests++; if (bif.sram_addr !== 21'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bif.sram_addr); end
        n_tests++; if (bif.sram_dout !== 8'd0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", bif.sram_dout); end
        n_tests++; if ({bif.a_ack, bif.b_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b expected 00", {bif.a_ack, bif.b_ack}); end
        n_tests++; if ({bif.a_rdata, bif.b_rdata} !== 16'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {bif.a_rdata, bif.b_rdata}); end
        n_tests++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bif.busy); end
        reset_n = 1'b1;
        repeat (2) @(negedge sysclk);
        n_tests++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bif.busy); end
    endtask

    task automatic test_single_read();
        int lat, oel, wel; bit sok, oth;
        preload(21'h01234, 8'h5A);
        access(1'b0, 1'b0, 21'h01234, 8'h00, lat, oel, wel, sok, oth);
        n_tests++; if (lat != AC) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", lat, AC); end
        n_tests++; if (oel != AC) begin n_fail++; $display("FAIL read_oe_width: got %0d expected %0d", oel, AC); end
        n_tests++; if (wel != 0) begin n_fail++; $display("FAIL read_we_width: got %0d expected 0", wel); end
        n_tests++; if (bif.a_rdata !== 8'h5A) begin n_fail++; $display("FAIL read_data: got %h expected 5a", bif.a_rdata); end
        n_tests++; if (oth) begin n_fail++; $display("FAIL read_b_ack: got 1 expected 0"); end
    endtask

    task automatic test_single_write();
        int lat, oel, wel; bit sok, oth;
        preload(21'h000010, 8'h11);
        preload(21'h100010, 8'h00);
        access(1'b1, 1'b1, 21'h100010, 8'hC3, lat, oel, wel, sok, oth);
        ref_mem[21'h100010] = 8'hC3;
        n_tests++; if (lat != AC + 1) begin n_fail++; $display("FAIL write_latency: got %0d expected %0d", lat, AC + 1); end
        n_tests++; if (wel != AC) begin n_fail++; $display("FAIL write_we_width: got %0d expected %0d", wel, AC); end
        n_tests++; if (oel != 0) begin n_fail++; $display("FAIL write_oe_width: got %0d expected 0", oel); end
        n_tests++; if (!sok) begin n_fail++; $display("FAIL write_addr_setup_hold: got unstable expected stable"); end
        n_tests++; if (oth) begin n_fail++; $display("FAIL write_a_ack: got 1 expected 0"); end
        n_tests++; if (mem[21'h100010] !== 8'hC3) begin n_fail++; $display("FAIL write_mem_upper: got %h expected c3", mem[21'h100010]); end
        n_tests++; if (mem[21'h000010] !== 8'h11) begin n_fail++; $display("FAIL write_mem_lower: got %h expected 11", mem[21'h000010]); end
        access(1'b0, 1'b0, 21'h100010, 8'h00, lat, oel, wel, sok, oth);
        n_tests++; if (bif.a_rdata !== 8'hC3) begin n_fail++; $display("FAIL readback_upper: got %h expected c3", bif.a_rdata); end
        access(1'b0, 1'b0, 21'h000010, 8'h00, lat, oel, wel, sok, oth);
        n_tests++; if (bif.a_rdata !== 8'h11) begin n_fail++; $display("FAIL readback_lower: got %h expected 11", bif.a_rdata); end
        n_tests++; if (bif.b_rdata !== 8'h00) begin n_fail++; $display("FAIL b_rdata_held: got %h expected 00", bif.b_rdata); end
    endtask

    task automatic test_arbitration();
        bit grants[$];
        bit rel_a, rel_b, expb;
        do_reset();
        rel_a = 1'b0; rel_b = 1'b0;
        drive_req(1'b0, 1'b1, 1'b0, pool_addr(3), 8'h00);
        drive_req(1'b1, 1'b1, 1'b0, pool_addr(20), 8'h00);
        for (int k = 0; k < 300 && grants.size() < 6; k++) begin
            @(negedge sysclk);
            if (bif.a_ack === 1'b1) begin grants.push_back(1'b0); bif.a_req = 1'b0; rel_a = 1'b1; end
            else if (rel_a) begin bif.a_req = 1'b1; rel_a = 1'b0; end
            if (bif.b_ack === 1'b1) begin grants.push_back(1'b1); bif.b_req = 1'b0; rel_b = 1'b1; end
            else if (rel_b) begin bif.b_req = 1'b1; rel_b = 1'b0; end
        end
        bif.a_req = 1'b0; bif.b_req = 1'b0;
        repeat (3) @(negedge sysclk);
        n_tests++; if (grants.size() != 6) begin n_fail++; $display("FAIL arb_grant_count: got %0d expected 6", grants.size()); end
        foreach (grants[i]) begin
            expb = RR ? bit'(i % 2) : 1'b0;
            n_tests++; if (grants[i] !== expb) begin n_fail++; $display("FAIL arb_grant_%0d: got port %0d expected port %0d", i, grants[i], expb); end
        end
    endtask

    task automatic test_back_to_back();
        int last_ack, lowcnt, done;
        bit raise;
        logic [20:0] cur;
        @(negedge sysclk);
        cur = pool_addr(int'($urandom_range(0, 31)));
        drive_req(1'b0, 1'b1, 1'b0, cur, 8'h00);
        last_ack = -1; lowcnt = 0; done = 0; raise = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge sysclk);
            if (bif.busy === 1'b0) lowcnt++;
            if (bif.a_ack === 1'b1) begin
                n_tests++; if (bif.a_rdata !== ref_mem[cur]) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", bif.a_rdata, ref_mem[cur]); end
                if (last_ack >= 0) begin
                    n_tests++; if (c - last_ack != AC + 2) begin n_fail++; $display("FAIL b2b_period: got %0d expected %0d", c - last_ack, AC + 2); end
                    n_tests++; if (lowcnt != 1) begin n_fail++; $display("FAIL b2b_busy_gap: got %0d expected 1", lowcnt); end
                end
                last_ack = c; lowcnt = 0; done++;
                bif.a_req = 1'b0; raise = 1'b1;
                if (done == 6) break;
            end else if (raise) begin
                cur = pool_addr(int'($urandom_range(0, 31)));
                drive_req(1'b0, 1'b1, 1'b0, cur, 8'h00);
                raise = 1'b0;
            end
        end
        bif.a_req = 1'b0;
        n_tests++; if (done != 6) begin n_fail++; $display("FAIL b2b_count: got %0d expected 6", done); end
        n_tests++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt); end
    endtask

    task automatic test_random();
        bit          pend [2];
        bit          cwe  [2];
        logic [20:0] cad  [2];
        logic [7:0]  cwd  [2];
        logic [7:0]  last_rd [2];
        int          issued [2];
        int          done [2];
        do_reset();
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; issued[p] = 0; done[p] = 0; last_rd[p] = 8'h00;
        end
        for (int c = 0; c < 3000 && (done[0] < 12 || done[1] < 12); c++) begin
            @(negedge sysclk);
            for (int p = 0; p < 2; p++) begin
                if (get_ack(p[0]) === 1'b1) begin
                    n_tests++; if (!pend[p]) begin n_fail++; $display("FAIL rnd_spurious_ack_%0d: got ack expected none", p); end
                    if (!cwe[p]) begin
                        n_tests++; if (get_rdata(p[0]) !== ref_mem[cad[p]]) begin n_fail++; $display("FAIL rnd_read_%0d: got %h expected %h at %h", p, get_rdata(p[0]), ref_mem[cad[p]], cad[p]); end
                        last_rd[p] = ref_mem[cad[p]];
                    end else begin
                        n_tests++; if (get_rdata(p[0]) !== last_rd[p]) begin n_fail++; $display("FAIL rnd_rdata_hold_%0d: got %h expected %h", p, get_rdata(p[0]), last_rd[p]); end
                        ref_mem[cad[p]] = cwd[p];
                    end
                    pend[p] = 1'b0; done[p]++;
                    drop_req(p[0]);
                end else if (!pend[p] && issued[p] < 12 && $urandom_range(0, 2) == 0) begin
                    cwe[p] = 1'($urandom);
                    cad[p] = pool_addr(int'($urandom_range(0, 31)));
                    cwd[p] = 8'($urandom);
                    drive_req(p[0], 1'b1, cwe[p], cad[p], cwd[p]);
                    pend[p] = 1'b1; issued[p]++;
                end
            end
        end
        bif.a_req = 1'b0; bif.b_req = 1'b0;
        n_tests++; if (done[0] != 12 || done[1] != 12) begin n_fail++; $display("FAIL rnd_completed: got %0d/%0d expected 12/12", done[0], done[1]); end
        n_tests++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL rnd_strobe_overlap: got %0d expected 0", overlap_cnt); end
    endtask

    task automatic test_reset_mid_write();
        bit found;
        int lat;
        preload(21'h000077, 8'h00);
        repeat (2) @(negedge sysclk);
        drive_req(1'b1, 1'b1, 1'b1, 21'h000077, 8'h9E);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sysclk);
            if (bif.sram_we_n === 1'b0) begin found = 1'b1; break; end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rst_wr_strobe_seen: got none expected we_n low"); end
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (bif.sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_wr_we_n: got %b expected 1", bif.sram_we_n); end
        n_tests++; if (bif.b_ack !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ack: got %b expected 0", bif.b_ack); end
        n_tests++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL rst_wr_busy: got %b expected 0", bif.busy); end
        n_tests++; if ({bif.sram_addr, bif.sram_dout} !== 29'd0) begin n_fail++; $display("FAIL rst_wr_addr_dout: got %h/%h expected 0/0", bif.sram_addr, bif.sram_dout); end
        n_tests++; if ({bif.a_rdata, bif.b_rdata} !== 16'd0) begin n_fail++; $display("FAIL rst_wr_rdata: got %h expected 0", {bif.a_rdata, bif.b_rdata}); end
        @(negedge sysclk);
        reset_n = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge sysclk);
            if (bif.b_ack === 1'b1) begin lat = k - 1; break; end
        end
        bif.b_req = 1'b0;
        ref_mem[21'h000077] = 8'h9E;
        n_tests++; if (lat != AC + 1) begin n_fail++; $display("FAIL rst_wr_resume_latency: got %0d expected %0d", lat, AC + 1); end
        n_tests++; if (mem[21'h000077] !== 8'h9E) begin n_fail++; $display("FAIL rst_wr_resume_data: got %h expected 9e", mem[21'h000077]); end
    endtask

    initial begin
        reset_n = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 21'd0, 8'd0);
        drive_req(1'b1, 1'b0, 1'b0, 21'd0, 8'd0);
        for (int i = 0; i < 32; i++) preload(pool_addr(i), 8'($urandom));
        #1 reset_n = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_arbitration();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        repeat (2) @(negedge sysclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
